// File: rtl/dsp_pkg.sv
// Shared definitions for the EX/MEM retire buffer: flag bit positions,
// default widths, occupancy states and the packed entry layout.
package dsp_pkg;

  localparam int FLAG_Z  = 0;
  localparam int FLAG_OV = 1;
  localparam int FLAG_C  = 2;
  localparam int FLAG_N  = 3;

  localparam int FLAGS_W      = 4;
  localparam int SATCNT_W_DEF = 16;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  // Entry layout, MSB first: {result, flags, saturate, rd, wb_en}
  function automatic int entry_w(input int data_w, input int rd_w);
    return data_w + FLAGS_W + 1 + rd_w + 1;
  endfunction

endpackage

// File: rtl/skid_fifo2.sv
// Generic two-entry valid/ready FIFO with flush; slot0 is always the head so
// the output comes straight from a register.
//
//   state     | meaning
//   OCC_EMPTY | no entries, out_valid low
//   OCC_ONE   | slot0 holds the head
//   OCC_FULL  | slot0 head, slot1 next; input refused
module skid_fifo2
  import dsp_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  occ_e         occ_q;
  logic [W-1:0] slot0_q;
  logic [W-1:0] slot1_q;
  logic         push;
  logic         pop;

  assign in_ready  = !rst && (occ_q != OCC_FULL);
  assign out_valid = (occ_q != OCC_EMPTY);
  assign out_data  = slot0_q;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q   <= OCC_EMPTY;
      slot0_q <= '0;
      slot1_q <= '0;
    end else if (flush) begin
      occ_q <= OCC_EMPTY;
    end else begin
      case (occ_q)
        OCC_EMPTY: begin
          if (push) begin
            slot0_q <= in_data;
            occ_q   <= OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (push && pop) begin
            slot0_q <= in_data;
          end else if (push) begin
            slot1_q <= in_data;
            occ_q   <= OCC_FULL;
          end else if (pop) begin
            occ_q <= OCC_EMPTY;
          end
        end
        OCC_FULL: begin
          // push is impossible here, so a pop simply promotes slot1
          if (pop) begin
            slot0_q <= slot1_q;
            occ_q   <= OCC_ONE;
          end
        end
        default: occ_q <= OCC_EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/ex_mem_retire_buffer.sv
// EX-to-MEM retire buffer: packs ALU results into a two-entry skid FIFO and
// keeps the DSP saturation status, which only moves when an entry retires.
module ex_mem_retire_buffer
  import dsp_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int RD_W     = 5,
  parameter int SATCNT_W = SATCNT_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_result,
  input  logic [3:0]          in_flags,
  input  logic                in_saturate,
  input  logic [RD_W-1:0]     in_rd,
  input  logic                in_wb_en,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_result,
  output logic [3:0]          out_flags,
  output logic [RD_W-1:0]     out_rd,
  output logic                out_wb_en,
  input  logic                flush,
  input  logic                sat_clr,
  output logic                sat_sticky,
  output logic [SATCNT_W-1:0] sat_count
);

  localparam int EW = entry_w(DATA_W, RD_W);

  logic [EW-1:0]       in_entry;
  logic [EW-1:0]       head;
  logic                head_valid;
  logic [DATA_W-1:0]   head_result;
  logic [3:0]          head_flags;
  logic                head_sat;
  logic [RD_W-1:0]     head_rd;
  logic                head_wb_en;
  logic                retire;
  logic                sat_event;
  logic                sat_sticky_q, sat_sticky_d;
  logic [SATCNT_W-1:0] sat_count_q, sat_count_d;

  assign in_entry = {in_result, in_flags, in_saturate, in_rd, in_wb_en};

  skid_fifo2 #(
    .W(EW)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_entry),
    .out_valid(head_valid),
    .out_ready(out_ready),
    .out_data (head)
  );

  assign {head_result, head_flags, head_sat, head_rd, head_wb_en} = head;

  // Slots keep stale data after a flush or pop, so the payload is masked
  assign out_valid  = head_valid;
  assign out_result = head_valid ? head_result : '0;
  assign out_flags  = head_valid ? head_flags : '0;
  assign out_rd     = head_valid ? head_rd : '0;
  assign out_wb_en  = head_valid && head_wb_en;

  // A retire coinciding with flush still counts: MEM already took the entry
  assign retire    = head_valid && out_ready;
  assign sat_event = retire && head_sat && head_flags[FLAG_OV];

  always_comb begin
    sat_sticky_d = sat_sticky_q;
    sat_count_d  = sat_count_q;
    if (sat_event) begin
      sat_sticky_d = 1'b1;
      if (sat_clr) begin
        sat_count_d = SATCNT_W'(1);
      end else if (!(&sat_count_q)) begin
        sat_count_d = sat_count_q + SATCNT_W'(1);
      end
    end else if (sat_clr) begin
      sat_sticky_d = 1'b0;
      sat_count_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_sticky_q <= 1'b0;
      sat_count_q  <= '0;
    end else begin
      sat_sticky_q <= sat_sticky_d;
      sat_count_q  <= sat_count_d;
    end
  end

  assign sat_sticky = sat_sticky_q;
  assign sat_count  = sat_count_q;

endmodule

// File: tb/tb_ex_mem_retire_buffer.sv
// Self-checking bench: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_ex_mem_retire_buffer;

  localparam int DW = 32;
  localparam int RW = 5;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_result = '0;
  logic [3:0]    in_flags = '0;
  logic          in_saturate = 1'b0;
  logic [RW-1:0] in_rd = '0;
  logic          in_wb_en = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_result;
  logic [3:0]    out_flags;
  logic [RW-1:0] out_rd;
  logic          out_wb_en;
  logic          flush = 1'b0;
  logic          sat_clr = 1'b0;
  logic          sat_sticky;
  logic [CW-1:0] sat_count;

  int checks = 0;
  int failures = 0;

  ex_mem_retire_buffer #(.DATA_W(DW), .RD_W(RW), .SATCNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_flags(in_flags), .in_saturate(in_saturate), .in_rd(in_rd), .in_wb_en(in_wb_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_flags(out_flags), .out_rd(out_rd), .out_wb_en(out_wb_en),
    .flush(flush), .sat_clr(sat_clr), .sat_sticky(sat_sticky), .sat_count(sat_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: a FIFO of at most two records plus the status pair
  typedef struct {
    logic [DW-1:0] res;
    logic [3:0]    fl;
    logic          sat;
    logic [RW-1:0] rd;
    logic          wb;
  } ent_t;

  ent_t          mq[$];
  ent_t          m_new;
  logic          m_sticky = 1'b0;
  logic [CW-1:0] m_cnt = '0;
  logic          m_acc, m_ret, m_ev;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_sticky = 1'b0;
      m_cnt    = '0;
    end else begin
      m_acc = in_valid && (mq.size() < 2);
      m_ret = out_ready && (mq.size() > 0);
      m_ev  = m_ret && mq[0].sat && mq[0].fl[1];
      if (m_ev) begin
        m_sticky = 1'b1;
        m_cnt    = sat_clr ? CW'(1) : ((m_cnt == {CW{1'b1}}) ? m_cnt : m_cnt + 1'b1);
      end else if (sat_clr) begin
        m_sticky = 1'b0;
        m_cnt    = '0;
      end
      if (flush) begin
        mq.delete();
      end else begin
        if (m_ret) void'(mq.pop_front());
        if (m_acc) begin
          m_new.res = in_result; m_new.fl = in_flags; m_new.sat = in_saturate;
          m_new.rd  = in_rd;     m_new.wb = in_wb_en;
          mq.push_back(m_new);
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("cmp_in_ready", in_ready, !rst && (mq.size() < 2));
    chk("cmp_out_valid", out_valid, mq.size() > 0);
    if (mq.size() > 0) begin
      chk("cmp_out_result", out_result, mq[0].res);
      chk("cmp_out_flags", out_flags, mq[0].fl);
      chk("cmp_out_rd", out_rd, mq[0].rd);
      chk("cmp_out_wb_en", out_wb_en, mq[0].wb);
    end else begin
      chk("cmp_out_idle", {out_result, out_flags, out_rd, out_wb_en}, 64'd0);
    end
    chk("cmp_sat_sticky", sat_sticky, m_sticky);
    chk("cmp_sat_count", sat_count, m_cnt);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] r, input logic [3:0] f,
                       input logic s, input logic [RW-1:0] d, input logic wb);
    in_valid = v; in_result = r; in_flags = f; in_saturate = s; in_rd = d; in_wb_en = wb;
  endtask

  initial begin
    #1 rst = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_sat", {sat_sticky, sat_count}, 0);
    cyc(); cyc();
    rst = 1'b0;
    #1;
    chk("rst_release_in_ready", in_ready, 1);

    // Single pass
    cyc();
    drive(1, 32'h30, 4'h0, 0, 5'd5, 1); out_ready = 1;
    cyc();
    drive(0, 0, 0, 0, 0, 0);
    chk("t1_out_valid", out_valid, 1);
    chk("t1_out_result", out_result, 32'h30);
    chk("t1_out_rd", out_rd, 5);
    cyc();
    chk("t1_drained", out_valid, 0);

    // Backpressure
    out_ready = 0;
    drive(1, 32'h11, 0, 0, 1, 1); cyc();
    drive(1, 32'h22, 0, 0, 2, 1); cyc();
    chk("t2_full_in_ready", in_ready, 0);
    drive(1, 32'h33, 0, 0, 3, 1); cyc();
    drive(0, 0, 0, 0, 0, 0);
    chk("t2_head_11", out_result, 32'h11);
    out_ready = 1; cyc();
    chk("t2_head_22", out_result, 32'h22);
    cyc();
    chk("t2_33_dropped", out_valid, 0);

    // Saturation counted on retire only
    out_ready = 0;
    drive(1, 32'h7FFF_FFFF, 4'b0010, 1, 7, 1); cyc();
    drive(0, 0, 0, 0, 0, 0);
    chk("t3_accept_no_status", {sat_sticky, sat_count}, 0);
    out_ready = 1; cyc();
    chk("t3_retire_sticky", sat_sticky, 1);
    chk("t3_retire_count", sat_count, 1);

    // Flush discards buffered saturated entries and a same-cycle accept
    out_ready = 0;
    drive(1, 32'hA, 4'b0010, 1, 1, 1); cyc();
    drive(1, 32'hB, 4'b0010, 1, 2, 1); cyc();
    flush = 1; drive(1, 32'hC, 4'b0010, 1, 3, 1); cyc();
    flush = 0; drive(0, 0, 0, 0, 0, 0);
    chk("t4_flush_out_valid", out_valid, 0);
    chk("t4_flush_in_ready", in_ready, 1);
    chk("t4_flush_count", sat_count, 1);
    out_ready = 1; cyc();
    chk("t4_accept_discarded", out_valid, 0);

    // Count to 3, then clear racing an event
    drive(1, 32'h1, 4'b0010, 1, 1, 1); cyc(); cyc();
    drive(0, 0, 0, 0, 0, 0); cyc();
    chk("t5_count3", sat_count, 3);
    out_ready = 0;
    drive(1, 32'h2, 4'b0010, 1, 1, 1); cyc();
    drive(0, 0, 0, 0, 0, 0);
    out_ready = 1; sat_clr = 1; cyc();
    sat_clr = 0;
    chk("t5_race_sticky", sat_sticky, 1);
    chk("t5_race_count", sat_count, 1);
    drive(1, 32'h3, 4'b1010, 1, 1, 0);
    for (int i = 0; i < 300; i++) cyc();
    drive(0, 0, 0, 0, 0, 0); cyc(); cyc();
    chk("t5_count_all_ones", sat_count, {CW{1'b1}});

    // Async reset between edges
    out_ready = 0;
    drive(1, 32'h44, 0, 0, 4, 1); cyc();
    drive(0, 0, 0, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_out_valid", out_valid, 0);
    chk("t6_async_sat", {sat_sticky, sat_count}, 0);
    chk("t6_async_in_ready", in_ready, 0);
    cyc();
    chk("t6_held_in_ready", in_ready, 0);
    #2 rst = 1'b0;
    #1;
    chk("t6_release_in_ready", in_ready, 1);

    // Randomized traffic
    cyc();
    for (int i = 0; i < 4000; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom, 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      sat_clr   = ($urandom_range(0, 39) == 0);
      rst       = ($urandom_range(0, 299) == 0);
      cyc();
    end
    rst = 0; flush = 0; sat_clr = 0;
    drive(0, 0, 0, 0, 0, 0);
    cyc(); cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
